// File: rtl/vaelix_auth_initiator_if.sv
// rtl/vaelix_auth_initiator_if.sv - signal bundle between the auth initiator and the harness/lock
//
// Signals:
//   start       launch request from the host sequencer
//   dut_uo_out  lock uo_out observed by the initiator
//   dut_rst_n   lock rst_n driven by the initiator
//   dut_ui_in   lock ui_in driven by the initiator
//   busy        sequence in progress
//   done        one-cycle pulse on PASS/FAIL entry
//   pass, fail  sticky result flags
//   retry_cnt   retries consumed in the current/last run
//   violation   sticky spurious-VERIFIED flag
// Modports: master = initiator view, slave = harness/sequencer view.
interface vaelix_auth_initiator_if;
  logic       start;
  logic [7:0] dut_uo_out;
  logic       dut_rst_n;
  logic [7:0] dut_ui_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [3:0] retry_cnt;
  logic       violation;

  modport master (
    input  start, dut_uo_out,
    output dut_rst_n, dut_ui_in, busy, done, pass, fail, retry_cnt, violation
  );

  modport slave (
    output start, dut_uo_out,
    input  dut_rst_n, dut_ui_in, busy, done, pass, fail, retry_cnt, violation
  );
endinterface

// File: rtl/vaelix_auth_initiator.sv
// rtl/vaelix_auth_initiator.sv - Sentinel authorization handshake initiator with bounded retries
//
// Ports:
//   clk    single rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    vaelix_auth_initiator_if.master (start/dut_uo_out in; lock drive and status out)
// Optional feature: define SENTINEL_SPURIOUS_CHK_EN to enable the spurious-VERIFIED checker
// that drives bus.violation; otherwise violation is tied low.
module vaelix_auth_initiator #(
  parameter int         RST_HOLD      = 5,
  parameter logic [7:0] KEY           = 8'hB6,
  parameter logic [7:0] VERIFIED_CODE = 8'hC1,
  parameter int         TIMEOUT       = 15,
  parameter int         MAX_RETRY     = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  vaelix_auth_initiator_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_REL  = 3'd2;
  localparam logic [2:0] S_KEY  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_PASS = 3'd5;
  localparam logic [2:0] S_FAIL = 3'd6;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic       launch;

  logic       dut_rst_n_q, dut_rst_n_d;
  logic [7:0] dut_ui_in_q, dut_ui_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic       match;
  assign match = (bus.dut_uo_out == VERIFIED_CODE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (bus.start) begin
          state_d = S_HOLD;
          cnt_d   = 8'd1;
          retry_d = 4'd0;
          launch  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_REL;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      S_REL: state_d = S_KEY;
      S_KEY: begin
        state_d = S_WAIT;
        cnt_d   = 8'd1;
      end
      S_WAIT: begin
        // A match on the final timeout cycle still counts as a pass.
        if (match) begin
          state_d = S_PASS;
        end else if (cnt_q == WAIT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_HOLD;
            cnt_d   = 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    dut_rst_n_d = (state_d != S_HOLD);
    dut_ui_in_d = (state_d == S_KEY || state_d == S_WAIT) ? KEY : 8'h00;
    busy_d      = (state_d == S_HOLD) || (state_d == S_REL) ||
                  (state_d == S_KEY)  || (state_d == S_WAIT);
    done_d      = (state_q == S_WAIT) && (state_d == S_PASS || state_d == S_FAIL);
    pass_d      = pass_q;
    fail_d      = fail_q;
    if (launch) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (state_q == S_WAIT) begin
      if (state_d == S_PASS) pass_d = 1'b1;
      if (state_d == S_FAIL) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      retry_q     <= 4'd0;
      dut_rst_n_q <= 1'b0;
      dut_ui_in_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_ui_in_q <= dut_ui_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.dut_rst_n = dut_rst_n_q;
  assign bus.dut_ui_in = dut_ui_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;

`ifdef SENTINEL_SPURIOUS_CHK_EN
  // The lock's uo_out reflects what it saw one cycle earlier, so VERIFIED is only
  // legitimate when the previous cycle had the lock out of reset with the key applied.
  logic       prev_rst_n_q;
  logic [7:0] prev_ui_in_q;
  logic       violation_q;
  logic       spurious;

  assign spurious = prev_rst_n_q && match && (prev_ui_in_q != KEY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_rst_n_q <= 1'b0;
      prev_ui_in_q <= 8'h00;
      violation_q  <= 1'b0;
    end else begin
      prev_rst_n_q <= dut_rst_n_q;
      prev_ui_in_q <= dut_ui_in_q;
      if (spurious)    violation_q <= 1'b1;
      else if (launch) violation_q <= 1'b0;
    end
  end

  assign bus.violation = violation_q;
`else
  assign bus.violation = 1'b0;
`endif

endmodule

// File: tb/tb_vaelix_auth_initiator.sv
// tb/tb_vaelix_auth_initiator.sv - scoreboard bench for vaelix_auth_initiator
module tb_vaelix_auth_initiator;

  localparam logic [7:0] KEY_C  = 8'hB6;
  localparam logic [7:0] CODE_C = 8'hC1;

  typedef struct {
    int         cyc;
    logic       pass;
    logic       fail;
    logic [3:0] retry;
    logic       viol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Lock model: 0 echo, 1 answer from second attempt, 2 silent, 3 spurious VERIFIED
  int         mode = 0;
  logic       spur_en = 1'b0;
  int         falls = 0;
  int         falls_base = 0;
  logic       prev_rst_m = 1'b0;
  logic [7:0] lock_q = 8'h00;

  vaelix_auth_initiator_if bus();

  vaelix_auth_initiator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    prev_rst_m <= bus.dut_rst_n;
    if (prev_rst_m && !bus.dut_rst_n) falls <= falls + 1;
    if (bus.dut_rst_n && bus.dut_ui_in == KEY_C &&
        (mode == 0 || (mode == 1 && (falls - falls_base) >= 2)))
      lock_q <= CODE_C;
    else
      lock_q <= 8'h00;
  end

  assign bus.dut_uo_out = (mode == 3) ? ((spur_en && bus.dut_rst_n) ? CODE_C : 8'h00) : lock_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("pass", {31'd0, bus.pass}, {31'd0, e.pass});
        chk("fail", {31'd0, bus.fail}, {31'd0, e.fail});
        chk("retry_cnt", {28'd0, bus.retry_cnt}, {28'd0, e.retry});
        chk("violation", {31'd0, bus.violation}, {31'd0, e.viol});
      end
    end
  end

  task automatic push_exp(input int c, input logic p, input logic f, input logic [3:0] r,
                          input logic v);
    exp_t e;
    e.cyc = c; e.pass = p; e.fail = f; e.retry = r; e.viol = v;
    exp_q.push_back(e);
  endtask

  task automatic do_start(output int t);
    @(posedge clk); #1;
    bus.start = 1'b1;
    t = cyc;
    falls_base = falls;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic at_neg(input int n);
    forever begin
      @(negedge clk);
      if (cyc >= n) break;
    end
  endtask

  task automatic at_pos(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=done (cycle %0d)", name, cyc);
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_dut_rst_n", {31'd0, bus.dut_rst_n}, 32'd0);
    chk("rst_ui_in", {24'd0, bus.dut_ui_in}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_pass", {31'd0, bus.pass}, 32'd0);
    chk("rst_fail", {31'd0, bus.fail}, 32'd0);
    chk("rst_retry", {28'd0, bus.retry_cnt}, 32'd0);
    chk("rst_violation", {31'd0, bus.violation}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_dut_rst_n", {31'd0, bus.dut_rst_n}, 32'd1);

    // Nominal pass with waveform timing
    mode = 0;
    do_start(t);
    push_exp(t + 9, 1'b1, 1'b0, 4'd0, 1'b0);
    at_neg(t + 1);
    chk("nom_hold_first", {31'd0, bus.dut_rst_n}, 32'd0);
    chk("nom_busy", {31'd0, bus.busy}, 32'd1);
    at_neg(t + 5);
    chk("nom_hold_last", {31'd0, bus.dut_rst_n}, 32'd0);
    at_neg(t + 6);
    chk("nom_release", {31'd0, bus.dut_rst_n}, 32'd1);
    chk("nom_release_ui", {24'd0, bus.dut_ui_in}, 32'd0);
    at_neg(t + 7);
    chk("nom_key", {24'd0, bus.dut_ui_in}, {24'd0, KEY_C});
    drain("nominal", 40);
    chk("nom_pass_sticky", {31'd0, bus.pass}, 32'd1);
    chk("nom_ui_after", {24'd0, bus.dut_ui_in}, 32'd0);
    chk("nom_busy_after", {31'd0, bus.busy}, 32'd0);

    // Start while busy is ignored
    do_start(t);
    push_exp(t + 9, 1'b1, 1'b0, 4'd0, 1'b0);
    at_pos(t + 3);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain("busy_start", 40);

    // Single retry
    mode = 1;
    do_start(t);
    push_exp(t + 31, 1'b1, 1'b0, 4'd1, 1'b0);
    at_neg(t + 23);
    chk("retry_rehold", {31'd0, bus.dut_rst_n}, 32'd0);
    drain("retry", 60);

    // Retry exhaustion
    mode = 2;
    do_start(t);
    push_exp(t + 89, 1'b0, 1'b1, 4'd3, 1'b0);
    drain("exhaust", 120);
    chk("exh_ui_after", {24'd0, bus.dut_ui_in}, 32'd0);
    chk("exh_fail_sticky", {31'd0, bus.fail}, 32'd1);
    chk("exh_pass_clear", {31'd0, bus.pass}, 32'd0);
    chk("exh_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-sequence: run abandoned, no done
    mode = 0;
    do_start(t);
    at_pos(t + 8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    at_neg(t + 9);
    chk("mid_dut_rst_n", {31'd0, bus.dut_rst_n}, 32'd0);
    chk("mid_ui_in", {24'd0, bus.dut_ui_in}, 32'd0);
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_done", {31'd0, bus.done}, 32'd0);
    chk("mid_pass", {31'd0, bus.pass}, 32'd0);
    chk("mid_fail", {31'd0, bus.fail}, 32'd0);
    repeat (4) @(negedge clk);
    do_start(t);
    push_exp(t + 9, 1'b1, 1'b0, 4'd0, 1'b0);
    drain("after_reset", 40);

    // Spurious VERIFIED from RELEASE onward
    mode = 3;
    do_start(t);
    spur_en = 1'b1;
`ifdef SENTINEL_SPURIOUS_CHK_EN
    push_exp(t + 9, 1'b1, 1'b0, 4'd0, 1'b1);
    at_neg(t + 7);
    chk("spur_not_yet", {31'd0, bus.violation}, 32'd0);
    at_neg(t + 8);
    chk("spur_set", {31'd0, bus.violation}, 32'd1);
`else
    push_exp(t + 9, 1'b1, 1'b0, 4'd0, 1'b0);
    at_neg(t + 8);
    chk("spur_off", {31'd0, bus.violation}, 32'd0);
`endif
    drain("spurious", 40);
    spur_en = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
